// File: rtl/sram_like_bridge_pkg.sv
// Shared definitions for the sram-like bridge: FSM state codes, transfer sizes,
// kseg0/kseg1 window and the byte-strobe decode helper.
package sram_like_bridge_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // addr[31:30] of kseg0/kseg1; those windows collapse onto the low 512 MiB
    localparam logic [1:0] KSEG_SEL   = 2'b10;
    localparam int         KSEG_LOW_W = 29;

    typedef struct packed {
        logic       wr;
        logic [1:0] size;
        logic       err;
    } wen_dec_t;

    // Illegal strobe patterns still go out as a full-word write, flagged by err.
    function automatic wen_dec_t decode_wen(input logic [3:0] wen);
        wen_dec_t d;
        d.wr   = |wen;
        d.size = SIZE_W;
        d.err  = 1'b0;
        case (wen)
            4'b0000:                            d.size = SIZE_W;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: d.size = SIZE_B;
            4'b0011, 4'b1100:                   d.size = SIZE_H;
            4'b1111:                            d.size = SIZE_W;
            default: begin
                d.size = SIZE_W;
                d.err  = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sram_like_bridge_chan.sv
// One bridge channel: captures a CPU access, runs the req/addr_ok/data_ok
// handshake and holds the response in DONE until the whole pipeline may advance.
module sram_like_bridge_chan
    import sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic              all_ready,
    output logic [31:0]       cpu_rdata,
    output logic              done,
    output logic              wen_err,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata
);

    logic [1:0]        state_r;
    logic [1:0]        state_nx_s;
    logic              req_r;
    logic              wr_r;
    logic [1:0]        size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              wen_err_r;
    logic [ADDR_W-1:0] mapped_addr_s;
    wen_dec_t          dec_s;
    logic              capture_s;
    logic              resp_s;

    // Strobe pattern decode
    always_comb dec_s = decode_wen(cpu_wen);

    if (MAP_KSEG) begin : g_map
        // Virtual-to-physical mapping of kseg0/kseg1; everything else passes through
        always_comb begin
            if (cpu_addr[31:30] == KSEG_SEL) begin
                mapped_addr_s = {ADDR_W{1'b0}};
                mapped_addr_s[KSEG_LOW_W-1:0] = cpu_addr[KSEG_LOW_W-1:0];
            end else begin
                mapped_addr_s = cpu_addr;
            end
        end
    end else begin : g_pass
        // No mapping: physical equals virtual
        always_comb mapped_addr_s = cpu_addr;
    end

    // Capture and response-accept strobes
    always_comb begin
        capture_s = (state_r == ST_IDLE) && cpu_en;
        resp_s    = ((state_r == ST_ADDR) && bus_addr_ok && bus_data_ok) ||
                    ((state_r == ST_DATA) && bus_data_ok);
    end

    // Next-state logic; data_ok alone in ADDR is a stale response and is ignored
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cpu_en) state_nx_s = ST_ADDR;
                else        state_nx_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (bus_addr_ok && bus_data_ok) state_nx_s = ST_DONE;
                else if (bus_addr_ok)           state_nx_s = ST_DATA;
                else                            state_nx_s = ST_ADDR;
            end
            ST_DATA: begin
                if (bus_data_ok) state_nx_s = ST_DONE;
                else             state_nx_s = ST_DATA;
            end
            ST_DONE: begin
                if (all_ready) state_nx_s = ST_IDLE;
                else           state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State, request and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            req_r     <= 1'b0;
            wr_r      <= 1'b0;
            size_r    <= 2'd0;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= 32'h0000_0000;
            rdata_r   <= 32'h0000_0000;
            wen_err_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            req_r     <= (state_nx_s == ST_ADDR);
            wen_err_r <= capture_s && dec_s.err;
            if (capture_s) begin
                wr_r    <= dec_s.wr;
                size_r  <= dec_s.size;
                addr_r  <= mapped_addr_s;
                wdata_r <= cpu_wdata;
            end
            if (resp_s) begin
                rdata_r <= bus_rdata;
            end
        end
    end

    assign done      = (state_r == ST_DONE);
    assign cpu_rdata = rdata_r;
    assign wen_err   = wen_err_r;
    assign bus_req   = req_r;
    assign bus_wr    = wr_r;
    assign bus_size  = size_r;
    assign bus_addr  = addr_r;
    assign bus_wdata = wdata_r;

endmodule

// File: rtl/sram_like_bridge.sv
// NCH-channel CPU SRAM port to sram-like bus bridge; the pipeline stalls until
// every enabled channel has reached DONE.
module sram_like_bridge
    import sram_like_bridge_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int ADDR_W   = 32,
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        cpu_en,
    input  logic [4*NCH-1:0]      cpu_wen,
    input  logic [ADDR_W*NCH-1:0] cpu_addr,
    input  logic [32*NCH-1:0]     cpu_wdata,
    output logic [32*NCH-1:0]     cpu_rdata,
    output logic                  cpu_stall,
    output logic [NCH-1:0]        wen_err,
    output logic [NCH-1:0]        bus_req,
    output logic [NCH-1:0]        bus_wr,
    output logic [2*NCH-1:0]      bus_size,
    output logic [ADDR_W*NCH-1:0] bus_addr,
    output logic [32*NCH-1:0]     bus_wdata,
    input  logic [NCH-1:0]        bus_addr_ok,
    input  logic [NCH-1:0]        bus_data_ok,
    input  logic [32*NCH-1:0]     bus_rdata
);

    logic [NCH-1:0] done_s;
    logic           all_ready_s;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_chan
        sram_like_bridge_chan #(
            .ADDR_W   (ADDR_W),
            .MAP_KSEG (MAP_KSEG)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .cpu_en      (cpu_en[ch]),
            .cpu_wen     (cpu_wen[4*ch +: 4]),
            .cpu_addr    (cpu_addr[ADDR_W*ch +: ADDR_W]),
            .cpu_wdata   (cpu_wdata[32*ch +: 32]),
            .all_ready   (all_ready_s),
            .cpu_rdata   (cpu_rdata[32*ch +: 32]),
            .done        (done_s[ch]),
            .wen_err     (wen_err[ch]),
            .bus_req     (bus_req[ch]),
            .bus_wr      (bus_wr[ch]),
            .bus_size    (bus_size[2*ch +: 2]),
            .bus_addr    (bus_addr[ADDR_W*ch +: ADDR_W]),
            .bus_wdata   (bus_wdata[32*ch +: 32]),
            .bus_addr_ok (bus_addr_ok[ch]),
            .bus_data_ok (bus_data_ok[ch]),
            .bus_rdata   (bus_rdata[32*ch +: 32])
        );
    end

    // A channel is ready when idle-by-CPU or finished; stall is combinational on cpu_en
    always_comb all_ready_s = &(~cpu_en | done_s);

    assign cpu_stall = ~all_ready_s;

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed bench for sram_like_bridge: a 2-channel mapped instance plus a
// 1-channel unmapped instance, all expectations hand-computed.
module tb_sram_like_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpu_en;
    logic [7:0]  cpu_wen;
    logic [63:0] cpu_addr;
    logic [63:0] cpu_wdata;
    logic [63:0] cpu_rdata;
    logic        cpu_stall;
    logic [1:0]  wen_err;
    logic [1:0]  bus_req;
    logic [1:0]  bus_wr;
    logic [3:0]  bus_size;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [1:0]  bus_addr_ok;
    logic [1:0]  bus_data_ok;
    logic [63:0] bus_rdata;

    logic        n_en;
    logic [3:0]  n_wen;
    logic [31:0] n_addr;
    logic [31:0] n_wdata;
    logic [31:0] n_rdata_o;
    logic        n_stall;
    logic        n_wen_err;
    logic        n_req;
    logic        n_wr;
    logic [1:0]  n_size;
    logic [31:0] n_bus_addr;
    logic [31:0] n_bus_wdata;
    logic        n_addr_ok;
    logic        n_data_ok;
    logic [31:0] n_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_like_bridge #(.NCH(2), .ADDR_W(32), .MAP_KSEG(1'b1)) u_dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .wen_err(wen_err), .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    sram_like_bridge #(.NCH(1), .ADDR_W(32), .MAP_KSEG(1'b0)) u_dut_nomap (
        .clk(clk), .rst(rst), .cpu_en(n_en), .cpu_wen(n_wen), .cpu_addr(n_addr),
        .cpu_wdata(n_wdata), .cpu_rdata(n_rdata_o), .cpu_stall(n_stall),
        .wen_err(n_wen_err), .bus_req(n_req), .bus_wr(n_wr), .bus_size(n_size),
        .bus_addr(n_bus_addr), .bus_wdata(n_bus_wdata), .bus_addr_ok(n_addr_ok),
        .bus_data_ok(n_data_ok), .bus_rdata(n_rdata)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        cpu_en = 2'b00; cpu_wen = 8'h00; cpu_addr = 64'h0; cpu_wdata = 64'h0;
        bus_addr_ok = 2'b00; bus_data_ok = 2'b00; bus_rdata = 64'h0;
        n_en = 1'b0; n_wen = 4'h0; n_addr = 32'h0; n_wdata = 32'h0;
        n_addr_ok = 1'b0; n_data_ok = 1'b0; n_rdata = 32'h0;

        // Reset state
        next_cycle(); next_cycle(); settle();
        check("rst_req", bus_req, 64'h0);
        check("rst_stall", cpu_stall, 64'h0);
        check("rst_addr", bus_addr, 64'h0);
        check("rst_rdata", cpu_rdata, 64'h0);
        check("rst_size", bus_size, 64'h0);
        cpu_en = 2'b01; #1;
        check("rst_stall_en", cpu_stall, 64'h1);
        cpu_en = 2'b00;
        next_cycle(); rst = 1'b0;

        // T1: ch0 read 0xBFC0_0000, addr_ok+data_ok in cycle 1
        next_cycle();
        cpu_en = 2'b01; cpu_wen = 8'h00; cpu_addr[31:0] = 32'hBFC0_0000; settle();
        check("t1_stall_c0", cpu_stall, 64'h1);
        next_cycle();
        bus_addr_ok = 2'b01; bus_data_ok = 2'b01; bus_rdata[31:0] = 32'h2408_0001; settle();
        check("t1_req_c1", bus_req, 64'h1);
        check("t1_addr", bus_addr[31:0], 64'h1FC0_0000);
        check("t1_size", bus_size[1:0], 64'h2);
        check("t1_wr", bus_wr[0], 64'h0);
        check("t1_stall_c1", cpu_stall, 64'h1);
        next_cycle();
        bus_addr_ok = 2'b00; bus_data_ok = 2'b00; bus_rdata = 64'h0; settle();
        check("t1_stall_c2", cpu_stall, 64'h0);
        check("t1_rdata", cpu_rdata[31:0], 64'h2408_0001);
        check("t1_req_c2", bus_req, 64'h0);
        cpu_en = 2'b00;
        next_cycle(); settle();
        check("t1_idle_req", bus_req, 64'h0);

        // T2: ch1 halfword write, addr_ok at +3, data_ok at +5
        next_cycle();
        cpu_en = 2'b10; cpu_wen = 8'hC0;
        cpu_addr = 64'h8000_0102_0000_0000; cpu_wdata = 64'hAABB_0000_0000_0000; settle();
        check("t2_stall_c0", cpu_stall, 64'h1);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            bus_addr_ok = (c == 3) ? 2'b10 : 2'b00;
            bus_data_ok = (c == 5) ? 2'b10 : 2'b00;
            settle();
            check($sformatf("t2_req_c%0d", c), bus_req, (c <= 3) ? 64'h2 : 64'h0);
            check($sformatf("t2_stall_c%0d", c), cpu_stall, (c < 6) ? 64'h1 : 64'h0);
            if (c == 1) begin
                check("t2_wr", bus_wr[1], 64'h1);
                check("t2_size", bus_size[3:2], 64'h1);
                check("t2_addr", bus_addr[63:32], 64'h0000_0102);
                check("t2_wdata", bus_wdata[63:32], 64'hAABB_0000);
            end
        end
        cpu_en = 2'b00; bus_addr_ok = 2'b00; bus_data_ok = 2'b00;
        next_cycle();

        // T3: both channels; ch0 done early and must hold its data until ch1 finishes
        next_cycle();
        cpu_en = 2'b11; cpu_wen = 8'h00; cpu_addr = 64'hA000_2000_8000_1000; settle();
        check("t3_stall_c0", cpu_stall, 64'h1);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            bus_addr_ok = {c == 3, c == 1};
            bus_data_ok = {c == 5, (c == 1) || (c == 3)};
            bus_rdata   = (c == 1) ? 64'h0000_0000_1111_2222 :
                          (c == 3) ? 64'h0000_0000_BAD0_0000 :
                          (c == 5) ? 64'h3333_4444_BAD0_0001 : 64'h0;
            settle();
            check($sformatf("t3_stall_c%0d", c), cpu_stall, (c < 6) ? 64'h1 : 64'h0);
            if (c == 1) begin
                check("t3_addr", bus_addr, 64'h0000_2000_0000_1000);
                check("t3_req", bus_req, 64'h3);
            end
            if (c >= 2) check($sformatf("t3_rd0_c%0d", c), cpu_rdata[31:0], 64'h1111_2222);
        end
        check("t3_rd1", cpu_rdata[63:32], 64'h3333_4444);
        cpu_en = 2'b00; bus_addr_ok = 2'b00; bus_data_ok = 2'b00; bus_rdata = 64'h0;
        next_cycle();

        // T4: kseg2 and kuseg pass unchanged; unmapped instance passes kseg0 unchanged
        next_cycle();
        cpu_en = 2'b11; cpu_addr = 64'h0000_0040_C000_0010; settle();
        next_cycle();
        bus_addr_ok = 2'b11; bus_data_ok = 2'b11; settle();
        check("t4_addr_pass", bus_addr, 64'h0000_0040_C000_0010);
        next_cycle();
        bus_addr_ok = 2'b00; bus_data_ok = 2'b00; settle();
        check("t4_stall", cpu_stall, 64'h0);
        cpu_en = 2'b00;
        next_cycle();
        n_en = 1'b1; n_addr = 32'h9000_0000; settle();
        check("t4n_stall_c0", n_stall, 64'h1);
        next_cycle();
        n_addr_ok = 1'b1; n_data_ok = 1'b1; n_rdata = 32'hCAFE_0042; settle();
        check("t4n_addr", n_bus_addr, 64'h9000_0000);
        check("t4n_req", n_req, 64'h1);
        next_cycle();
        n_addr_ok = 1'b0; n_data_ok = 1'b0; settle();
        check("t4n_stall_c2", n_stall, 64'h0);
        check("t4n_rdata", n_rdata_o, 64'hCAFE_0042);
        n_en = 1'b0;
        next_cycle();

        // T5: illegal strobe 0101, then reset in DATA and a late data_ok
        next_cycle();
        cpu_en = 2'b10; cpu_wen = 8'h50; cpu_addr = 64'h0000_0200_0000_0000;
        cpu_wdata = 64'h1234_5678_0000_0000; settle();
        check("t5_err_c0", wen_err, 64'h0);
        next_cycle();
        bus_addr_ok = 2'b10; settle();
        check("t5_err_c1", wen_err, 64'h2);
        check("t5_size", bus_size[3:2], 64'h2);
        check("t5_wr", bus_wr[1], 64'h1);
        next_cycle();
        bus_addr_ok = 2'b00; settle();
        check("t5_err_c2", wen_err, 64'h0);
        check("t5_req_data", bus_req, 64'h0);
        rst = 1'b1; #1;
        check("t5_rst_wr", bus_wr, 64'h0);
        check("t5_rst_size", bus_size, 64'h0);
        check("t5_rst_addr", bus_addr, 64'h0);
        check("t5_rst_wdata", bus_wdata, 64'h0);
        check("t5_rst_stall_en", cpu_stall, 64'h1);
        cpu_en = 2'b00; #1;
        check("t5_rst_stall", cpu_stall, 64'h0);
        next_cycle(); rst = 1'b0;
        next_cycle();
        bus_data_ok = 2'b10; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF; settle();
        check("t5_late_req", bus_req, 64'h0);
        next_cycle();
        bus_data_ok = 2'b00; settle();
        check("t5_late_rdata", cpu_rdata, 64'h0);
        check("t5_late_req2", bus_req, 64'h0);
        check("t5_late_err", wen_err, 64'h0);
        // fresh read; a lone data_ok in ADDR must not complete it
        cpu_en = 2'b10; cpu_wen = 8'h00; settle();
        check("t5_new_stall", cpu_stall, 64'h1);
        next_cycle();
        bus_data_ok = 2'b10; settle();
        check("t5_addr_req", bus_req, 64'h2);
        next_cycle();
        bus_data_ok = 2'b00; settle();
        check("t5_stale_req", bus_req, 64'h2);
        check("t5_stale_stall", cpu_stall, 64'h1);
        bus_addr_ok = 2'b10; bus_data_ok = 2'b10; bus_rdata = 64'h5A5A_0001_0000_0000;
        next_cycle();
        bus_addr_ok = 2'b00; bus_data_ok = 2'b00; settle();
        check("t5_fin_stall", cpu_stall, 64'h0);
        check("t5_fin_rdata", cpu_rdata[63:32], 64'h5A5A_0001);
        cpu_en = 2'b00;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
